// File: rtl/kernel_loader.sv
// Coefficient loader: on a frame-start pulse, streams a 5x5 or 11x11 kernel
// from its ROM to the filter over a valid/ready handshake.
module kernel_loader #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_en,
    input  logic [1:0]        mode_sel,
    output logic              rom_rd_en,
    output logic [4:0]        rom5_addr,
    output logic [6:0]        rom11_addr,
    input  logic [DATA_W-1:0] rom5_data,
    input  logic [DATA_W-1:0] rom11_data,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic [DATA_W-1:0] coef_data,
    output logic [6:0]        coef_idx,
    output logic              busy,
    output logic              load_done,
    output logic [1:0]        active_kernel
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_5    = 2'b01;
    localparam logic [1:0] MODE_11   = 2'b10;
    localparam logic [6:0] LAST_5    = 7'd24;
    localparam logic [6:0] LAST_11   = 7'd120;

    state_t            state_r;
    logic [6:0]        idx_r;
    logic [1:0]        load_mode_r;
    logic [1:0]        active_kernel_r;
    logic              rom_rd_en_r;
    logic [4:0]        rom5_addr_r;
    logic [6:0]        rom11_addr_r;
    logic              coef_valid_r;
    logic [6:0]        coef_idx_r;
    logic              busy_r;
    logic              load_done_r;

    logic [6:0]        idx_inc_s;
    logic [6:0]        last_idx_s;
    logic              start_s;
    logic [DATA_W-1:0] coef_data_s;

    assign idx_inc_s  = idx_r + 7'd1;
    assign last_idx_s = (load_mode_r == MODE_11) ? LAST_11 : LAST_5;
    assign start_s    = frame_en && (mode_sel == MODE_5 || mode_sel == MODE_11)
                        && (mode_sel != active_kernel_r);

    // ROM data only arrives during PRESENT, so the offered word is a gated mux
    // of the ROM outputs (which the ROM holds while rd_en is low).
    always_comb begin
        coef_data_s = {DATA_W{1'b0}};
        if (coef_valid_r) begin
            if (load_mode_r == MODE_11) begin
                coef_data_s = rom11_data;
            end else begin
                coef_data_s = rom5_data;
            end
        end else begin
            coef_data_s = {DATA_W{1'b0}};
        end
    end

    // Load sequencer: state, index and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            idx_r           <= 7'd0;
            load_mode_r     <= MODE_NONE;
            active_kernel_r <= MODE_NONE;
            rom_rd_en_r     <= 1'b0;
            rom5_addr_r     <= 5'd0;
            rom11_addr_r    <= 7'd0;
            coef_valid_r    <= 1'b0;
            coef_idx_r      <= 7'd0;
            busy_r          <= 1'b0;
            load_done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    load_done_r <= 1'b0;
                    if (start_s) begin
                        load_mode_r  <= mode_sel;
                        idx_r        <= 7'd0;
                        rom_rd_en_r  <= 1'b1;
                        rom5_addr_r  <= 5'd0;
                        rom11_addr_r <= 7'd0;
                        busy_r       <= 1'b1;
                        state_r      <= FETCH;
                    end else if (frame_en && mode_sel == MODE_NONE) begin
                        active_kernel_r <= MODE_NONE;
                    end
                end
                FETCH: begin
                    rom_rd_en_r  <= 1'b0;
                    coef_valid_r <= 1'b1;
                    coef_idx_r   <= idx_r;
                    state_r      <= PRESENT;
                end
                PRESENT: begin
                    if (coef_ready) begin
                        coef_valid_r <= 1'b0;
                        if (idx_r == last_idx_s) begin
                            active_kernel_r <= load_mode_r;
                            busy_r          <= 1'b0;
                            load_done_r     <= 1'b1;
                            state_r         <= DONE;
                        end else begin
                            idx_r        <= idx_inc_s;
                            rom_rd_en_r  <= 1'b1;
                            rom5_addr_r  <= (load_mode_r == MODE_5)  ? idx_inc_s[4:0] : 5'd0;
                            rom11_addr_r <= (load_mode_r == MODE_11) ? idx_inc_s      : 7'd0;
                            state_r      <= FETCH;
                        end
                    end
                end
                DONE: begin
                    load_done_r <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    rom_rd_en_r  <= 1'b0;
                    coef_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    load_done_r  <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign rom_rd_en     = rom_rd_en_r;
    assign rom5_addr     = rom5_addr_r;
    assign rom11_addr    = rom11_addr_r;
    assign coef_valid    = coef_valid_r;
    assign coef_data     = coef_data_s;
    assign coef_idx      = coef_idx_r;
    assign busy          = busy_r;
    assign load_done     = load_done_r;
    assign active_kernel = active_kernel_r;

endmodule

// File: tb/tb_kernel_loader.sv
// Scoreboard bench for kernel_loader: ROM models, randomized stalls and frames,
// expected transfers queued by the stimulus and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_kernel_loader;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_en = 1'b0;
    logic [1:0]        mode_sel = 2'b00;
    logic              rom_rd_en;
    logic [4:0]        rom5_addr;
    logic [6:0]        rom11_addr;
    logic [DATA_W-1:0] rom5_data = '0;
    logic [DATA_W-1:0] rom11_data = '0;
    logic              coef_valid;
    logic              coef_ready = 1'b1;
    logic [DATA_W-1:0] coef_data;
    logic [6:0]        coef_idx;
    logic              busy;
    logic              load_done;
    logic [1:0]        active_kernel;

    kernel_loader #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .frame_en(frame_en), .mode_sel(mode_sel),
        .rom_rd_en(rom_rd_en), .rom5_addr(rom5_addr), .rom11_addr(rom11_addr),
        .rom5_data(rom5_data), .rom11_data(rom11_data),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .coef_idx(coef_idx), .busy(busy), .load_done(load_done),
        .active_kernel(active_kernel)
    );

    typedef struct {
        int              idx;
        logic [DATA_W-1:0] data;
        logic [1:0]      mode;
        int              cyc;
    } coef_t;
    typedef struct {
        logic [1:0] kernel;
        int         cyc;
    } done_t;

    coef_t coef_q[$];
    done_t done_q[$];

    logic [DATA_W-1:0] rom5_mem [32];
    logic [DATA_W-1:0] rom11_mem[128];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   stall_en = 1'b0;
    logic [1:0] model_active = 2'b00;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROMs: data one cycle after rd_en, held otherwise
    always @(posedge clk) begin
        if (rom_rd_en) begin
            rom5_data  <= rom5_mem[rom5_addr];
            rom11_data <= rom11_mem[rom11_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Ready driver: random backpressure when stalls are enabled
    initial forever begin
        @(posedge clk);
        #1;
        coef_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor: address checks, stall stability, transfers and load_done
    initial begin
        bit                pend;
        logic [DATA_W-1:0] pdata;
        logic [6:0]        pidx;
        coef_t             c;
        done_t             d;
        pend = 1'b0;
        pdata = '0;
        pidx = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (rom_rd_en) begin
                    if (coef_q.size() == 0) begin
                        chk("unexpected_rom_read", 64'd1, 64'd0);
                    end else if (coef_q[0].mode == 2'b01) begin
                        chk("rom5_addr", rom5_addr, coef_q[0].idx);
                        chk("rom11_addr_idle", rom11_addr, 0);
                    end else begin
                        chk("rom11_addr", rom11_addr, coef_q[0].idx);
                        chk("rom5_addr_idle", rom5_addr, 0);
                    end
                end
                if (pend) begin
                    chk("stall_valid", coef_valid, 1);
                    chk("stall_data", coef_data, pdata);
                    chk("stall_idx", coef_idx, pidx);
                end
                pend = coef_valid && !coef_ready;
                pdata = coef_data;
                pidx = coef_idx;
                if (coef_valid && coef_ready) begin
                    if (coef_q.size() == 0) begin
                        chk("unexpected_transfer", 64'd1, 64'd0);
                    end else begin
                        c = coef_q.pop_front();
                        chk("coef_idx", coef_idx, c.idx);
                        chk("coef_data", coef_data, c.data);
                        if (c.cyc >= 0) chk("coef_latency", cyc, c.cyc);
                    end
                end
                if (load_done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_load_done", 64'd1, 64'd0);
                    end else begin
                        d = done_q.pop_front();
                        chk("done_active_kernel", active_kernel, d.kernel);
                        chk("done_busy", busy, 0);
                        if (d.cyc >= 0) chk("done_latency", cyc, d.cyc);
                    end
                end
            end
        end
    end

    task automatic push_load(input logic [1:0] m, input int t, input bit timed);
        int    n;
        coef_t c;
        done_t d;
        n = (m == 2'b01) ? 25 : 121;
        for (int k = 0; k < n; k++) begin
            c.idx  = k;
            c.data = (m == 2'b01) ? rom5_mem[k] : rom11_mem[k];
            c.mode = m;
            c.cyc  = timed ? t + 2 + 2 * k : -1;
            coef_q.push_back(c);
        end
        d.kernel = m;
        d.cyc    = timed ? t + 2 * n + 1 : -1;
        done_q.push_back(d);
    endtask

    task automatic do_load(input logic [1:0] m, input bit stall, input bit inject,
                           input logic [1:0] inj_mode);
        bit seen;
        stall_en = stall;
        @(posedge clk);
        #1;
        mode_sel = m;
        frame_en = 1'b1;
        push_load(m, cyc, !stall);
        @(posedge clk);
        #1;
        frame_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (load_done) begin
                seen = 1'b1;
                frame_en = 1'b0;
                break;
            end
            if (inject && i == 7) begin
                mode_sel = inj_mode;
                frame_en = 1'b1;
            end else begin
                frame_en = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk("load_done_timeout", 64'd0, 64'd1);
        model_active = m;
        mode_sel = 2'b00;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_active_kernel", active_kernel, model_active);
        stall_en = 1'b0;
    endtask

    task automatic do_nop(input logic [1:0] m);
        @(posedge clk);
        #1;
        mode_sel = m;
        frame_en = 1'b1;
        if (m == 2'b00) model_active = 2'b00;
        @(posedge clk);
        #1;
        frame_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nop_rd_en", rom_rd_en, 0);
            chk("nop_busy", busy, 0);
            chk("nop_active_kernel", active_kernel, model_active);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, rom_rd_en, 0);
        chk({tag, "_rom5_addr"}, rom5_addr, 0);
        chk({tag, "_rom11_addr"}, rom11_addr, 0);
        chk({tag, "_coef_valid"}, coef_valid, 0);
        chk({tag, "_coef_data"}, coef_data, 0);
        chk({tag, "_coef_idx"}, coef_idx, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_load_done"}, load_done, 0);
        chk({tag, "_active_kernel"}, active_kernel, 0);
    endtask

    initial begin
        bit         hit;
        logic [1:0] r;
        for (int i = 0; i < 32; i++)  rom5_mem[i]  = DATA_W'($urandom);
        for (int i = 0; i < 128; i++) rom11_mem[i] = DATA_W'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        do_load(2'b01, 1'b0, 1'b0, 2'b00);
        do_nop(2'b01);
        do_load(2'b10, 1'b0, 1'b0, 2'b00);
        do_nop(2'b00);
        do_nop(2'b11);
        do_load(2'b01, 1'b1, 1'b1, 2'b10);

        // Reset in the middle of an 11x11 load at index 60
        stall_en = 1'b1;
        @(posedge clk);
        #1;
        mode_sel = 2'b10;
        frame_en = 1'b1;
        push_load(2'b10, cyc, 1'b0);
        @(posedge clk);
        #1;
        frame_en = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (coef_valid && coef_idx == 7'd60) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!hit) chk("idx60_timeout", 64'd0, 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        coef_q.delete();
        done_q.delete();
        model_active = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("postreset_load_done", load_done, 0);
            chk("postreset_busy", busy, 0);
        end
        do_load(2'b10, 1'b0, 1'b0, 2'b00);

        for (int it = 0; it < 8; it++) begin
            r = 2'($urandom_range(0, 3));
            if ((r == 2'b01 || r == 2'b10) && r != model_active) begin
                do_load(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)));
            end else begin
                do_nop(r);
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("coef_queue_empty", coef_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end
endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 Parameter: DATA_W, default 8, coefficient width in bits.
REQ-002 clk  input  1  system pixel clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 frame_en  input  1  one-cycle frame-start pulse; the only load trigger.
REQ-005 mode_sel  input  2  requested kernel: 00 none, 01 5x5, 10 11x11, 11 reserved.
REQ-006 rom_rd_en  output  1  read enable shared by both coefficient ROMs.
REQ-007 rom5_addr  output  5  5x5 ROM address.
REQ-008 rom11_addr  output  7  11x11 ROM address.
REQ-009 rom5_data  input  DATA_W  5x5 ROM data; valid one cycle after the rd_en cycle; held while rd_en=0.
REQ-010 rom11_data  input  DATA_W  11x11 ROM data; same timing as rom5_data.
REQ-011 coef_valid  output  1  coefficient offered to the filter.
REQ-012 coef_ready  input  1  filter accepts; transfer occurs when coef_valid and coef_ready are both 1 at a rising edge.
REQ-013 coef_data  output  DATA_W  offered coefficient.
REQ-014 coef_idx  output  7  index of the offered coefficient, starting at 0.
REQ-015 busy  output  1  load in progress.
REQ-016 load_done  output  1  one-cycle pulse after the last transfer.
REQ-017 active_kernel  output  2  kernel currently loaded in the filter (00/01/10).

Function
REQ-018 FSM states: IDLE, FETCH, PRESENT, DONE.
REQ-019 IDLE, frame_en=1, mode_sel in {01,10}, mode_sel != active_kernel: latch mode_sel as load_mode, set idx=0, go to FETCH.
REQ-020 IDLE, frame_en=1, mode_sel=00: active_kernel <= 00 at that edge; no ROM traffic; no load_done; stay IDLE.
REQ-021 IDLE, frame_en=1, mode_sel equal to active_kernel (nonzero), or mode_sel=11: no action; all outputs unchanged.
REQ-022 FETCH, one cycle: rom_rd_en=1; ROM address for load_mode = idx; the other ROM's address = 0; go to PRESENT.
REQ-023 PRESENT: coef_valid=1; coef_data = ROM data selected by load_mode; coef_idx = idx; rom_rd_en=0.
REQ-024 PRESENT: hold all outputs stable until transfer; coef_ready=0 stalls indefinitely.
REQ-025 On transfer, idx < N-1 (N=25 for 5x5, N=121 for 11x11): idx <= idx+1, go to FETCH.
REQ-026 On transfer, idx = N-1: active_kernel <= load_mode, go to DONE.
REQ-027 DONE, one cycle: load_done=1; go to IDLE.
REQ-028 busy=1 in FETCH and PRESENT only; coef_valid=1 in PRESENT only; rom_rd_en=1 in FETCH only.
REQ-029 mode_sel and frame_en are ignored outside IDLE, including in DONE; changes do not affect an in-progress load, and frames are not queued.
REQ-030 Latency with coef_ready=1 throughout, frame_en in cycle T: FETCH at T+1; index k offered at T+2+2k; load_done at T+51 (5x5) or T+243 (11x11).
REQ-031 idx never exceeds N-1; no address wraps past the kernel size.

Reset
REQ-032 rst=1 forces asynchronously: state=IDLE, idx=0, active_kernel=00, and all outputs 0 (rom_rd_en, both addresses, coef_valid, coef_data, coef_idx, busy, load_done).
REQ-033 Reset mid-load abandons the load; no load_done is issued; active_kernel=00.
REQ-034 First frame_en after reset deasserts with mode_sel in {01,10} always triggers a load.

Verification
REQ-035 Reset, coef_ready=1, frame_en at T, mode_sel=01 -> rom5_addr 0..24; coef_idx k offered at T+2+2k; load_done at T+51; active_kernel=01.
REQ-036 Then frame_en with mode_sel=01 -> no rom_rd_en, busy stays 0; then mode_sel=10 -> 121 transfers, load_done at T+243, active_kernel=10.
REQ-037 Random coef_ready stalls during 5x5 load -> coef_data/coef_idx stable while valid and not ready; exactly 25 transfers in order; data matches ROM contents.
REQ-038 frame_en with mode_sel=10 mid-load of 5x5 -> ignored; 5x5 completes; active_kernel=01.
REQ-039 rst asserted at idx=60 of an 11x11 load -> outputs 0 immediately, no load_done, active_kernel=00; next frame_en with mode_sel=10 reloads from idx 0.
REQ-040 frame_en with mode_sel=00 -> active_kernel=00 next cycle, no ROM reads; mode_sel=11 -> no change at all.
